// File: rtl/transmissor_serial.sv
// rtl/transmissor_serial.sv - start/data/stop serial transmitter with valid/ready word handshake
// Frame: one start bit (0), WIDTH data bits d[0] first, one stop bit (1); each bit lasts DIV clocks.
module transmissor_serial #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [0:WIDTH-1] d,
  input  logic             valid,
  output logic             ready,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;
  logic [0:WIDTH-1] shreg;
  logic             bit_end;

  assign bit_end = (cnt == CNT_LAST);
  assign busy    = ~ready;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
      sout  <= 1'b1;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            shreg <= d;
            cnt   <= '0;
            sout  <= 1'b0;
            ready <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            sout  <= shreg[0];
            shreg <= {shreg[1:WIDTH-1], 1'b0};
            state <= DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            // shreg[0] always holds the next bit to put on the line
            if (idx == IDX_LAST) begin
              sout  <= 1'b1;
              state <= STOP;
            end else begin
              idx   <= idx + 1'b1;
              sout  <= shreg[0];
              shreg <= {shreg[1:WIDTH-1], 1'b0};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt   <= '0;
            idx   <= '0;
            ready <= 1'b1;
            done  <= 1'b1;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          sout  <= 1'b1;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_transmissor_serial.sv
// tb/tb_transmissor_serial.sv - scoreboard bench for transmissor_serial over three WIDTH/DIV configurations
module tb_transmissor_serial;

  logic       clk = 1'b0;
  logic       clrn;
  logic       valid;
  logic [0:7] dd;
  int         tests = 0;
  int         fails = 0;

  always #4 clk = ~clk;

  task automatic chk(input string nm, input int g, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst%0d t=%0t: {sout,ready,done,busy} got %b want %b", nm, g, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 2) ? 5 : 8;
    localparam int V = (g == 0) ? 1 : ((g == 1) ? 4 : 3);
    logic       ready, sout, busy, done;
    logic [2:0] q[$];

    transmissor_serial #(.WIDTH(W), .DIV(V)) dut (
      .clk  (clk),
      .clrn (clrn),
      .d    (dd[0:W-1]),
      .valid(valid),
      .ready(ready),
      .sout (sout),
      .busy (busy),
      .done (done)
    );

    // Reference: an accepted word becomes (W+2)*V busy samples {sout,0,0} followed by one {1,1,1} done sample
    always @(posedge clk) begin
      logic b;
      if (clrn && valid && q.size() == 0) begin
        for (int k = 0; k < W + 2; k++) begin
          b = (k == 0) ? 1'b0 : ((k == W + 1) ? 1'b1 : dd[k-1]);
          for (int r = 0; r < V; r++) q.push_back({b, 2'b00});
        end
        q.push_back(3'b111);
      end
    end

    always @(negedge clk) begin
      logic [2:0] e;
      if (clrn) begin
        e = (q.size() != 0) ? q.pop_front() : 3'b110;
        chk("line", g, {sout, ready, done, busy}, {e, ~e[1]});
      end
    end

    always @(negedge clrn) begin
      q.delete();
      #1;
      chk("async_reset", g, {sout, ready, done, busy}, 4'b1100);
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clrn  = 1'b0;
    valid = 1'b1;
    dd    = 8'b01010101;
    repeat (2) @(negedge clk);
    #1 clrn = 1'b1;
    cyc();
    valid = 1'b0;
    repeat (50) cyc();

    dd = 8'b10100011; valid = 1'b1;
    cyc();
    valid = 1'b0;
    repeat (50) cyc();

    dd = 8'hFF; valid = 1'b1;
    cyc();
    valid = 1'b0;
    repeat (50) cyc();

    dd = 8'h00; valid = 1'b1;
    cyc();
    dd = 8'hFF;
    repeat (60) cyc();
    valid = 1'b0;
    repeat (50) cyc();

    dd = 8'($urandom); valid = 1'b1;
    cyc();
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      dd = ~dd;
      valid = i[0];
      cyc();
    end
    valid = 1'b0;
    repeat (50) cyc();

    dd = 8'($urandom); valid = 1'b1;
    cyc();
    valid = 1'b0;
    repeat (4) cyc();
    clrn = 1'b0;
    #2 clrn = 1'b1;
    repeat (30) cyc();

    for (int i = 0; i < 400; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      dd    = 8'($urandom);
      cyc();
    end
    valid = 1'b0;
    repeat (60) cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
